// File: rtl/dp_isa_pkg.sv
// Instruction-set and sequencer constants shared by the program sequencer, its ROM and the board top.
package dp_isa_pkg;

  localparam int SEQ_ADDR_W = 5;

  // opcode field positions: [15:12] major, [11:8] A/dst, [7:4] ext, [3:0] B/src
  localparam int OP_MAJOR_LSB = 12;
  localparam int OP_A_LSB     = 8;
  localparam int OP_EXT_LSB   = 4;
  localparam int OP_B_LSB     = 0;

  localparam logic [15:0] OP_NOP  = 16'h0000;
  localparam logic [15:0] OP_HALT = 16'hFFFF;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_CARRY = 3;
  localparam int FLAG_PAR   = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_ISSUE = ST_ISSUE,
    S_DONE  = ST_DONE
  } seq_state_e;

  function automatic logic [3:0] major_op(input logic [15:0] word);
    return word[OP_MAJOR_LSB +: 4];
  endfunction

endpackage

// File: rtl/seq_instr_rom.sv
// Synchronous instruction memory with a one-cycle registered read; contents are
// written through the load port before a run (board loader or bench).
module seq_instr_rom
  import dp_isa_pkg::*;
#(
  parameter int ADDR_W = SEQ_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] addr,
  output logic [15:0]       data
);

  logic [15:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    data <= mem[addr];
  end

endmodule

// File: rtl/dp_program_sequencer.sv
// Fetches instruction words from a synchronous ROM and issues them to the datapath,
// feeding each instruction's carry flag forward as the next instruction's carry-in.
//   state | meaning
//   IDLE  | waiting for start, opcode held at NOP
//   FETCH | ROM read in flight; captures flags of the previous issue
//   ISSUE | ROM data valid; issue word or stop on HALT / length
//   DONE  | one-cycle done pulse, then back to IDLE
module dp_program_sequencer
  import dp_isa_pkg::*;
#(
  parameter int          ADDR_W    = SEQ_ADDR_W,
  parameter logic [15:0] NOP_WORD  = OP_NOP,
  parameter logic [15:0] HALT_WORD = OP_HALT,
  parameter int          CARRY_BIT = FLAG_CARRY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic [ADDR_W:0]   prog_len,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  output logic [15:0]       dp_opcode,
  output logic              dp_cin,
  input  logic [4:0]        dp_flags,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  seq_state_e        state, state_n;
  logic [ADDR_W-1:0] addr_n, pc_n;
  logic [15:0]       op_n;
  logic              cin_n, busy_n, done_n;
  logic [4:0]        flag_reg, flag_n;
  logic [ADDR_W:0]   count, count_n, cnt_inc, len_eff;
  logic              armed;
  logic              unused_flags;

  // Only the carry is consumed; the rest of the captured flags stay for debug visibility.
  assign unused_flags = ^flag_reg;
  assign len_eff      = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
  assign cnt_inc      = count + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      imem_addr <= '0;
      pc        <= '0;
      dp_opcode <= NOP_WORD;
      dp_cin    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      flag_reg  <= '0;
      count     <= '0;
      armed     <= 1'b0;
    end else begin
      state     <= state_n;
      imem_addr <= addr_n;
      pc        <= pc_n;
      dp_opcode <= op_n;
      dp_cin    <= cin_n;
      busy      <= busy_n;
      done      <= done_n;
      flag_reg  <= flag_n;
      count     <= count_n;
      armed     <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = imem_addr;
    pc_n    = pc;
    op_n    = dp_opcode;
    cin_n   = dp_cin;
    busy_n  = busy;
    done_n  = 1'b0;
    flag_n  = flag_reg;
    count_n = count;
    if (!pause) begin
      unique case (state)
        S_IDLE: begin
          op_n = NOP_WORD;
          // armed blocks a start that lands on the first edge after reset release
          if (start && armed) begin
            if (len_eff == '0) begin
              state_n = S_DONE;
              done_n  = 1'b1;
            end else begin
              addr_n  = '0;
              flag_n  = '0;
              count_n = '0;
              busy_n  = 1'b1;
              state_n = S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (count != '0) flag_n = dp_flags;
          state_n = S_ISSUE;
        end
        S_ISSUE: begin
          if (imem_data == HALT_WORD) begin
            op_n    = NOP_WORD;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = S_DONE;
          end else begin
            op_n    = imem_data;
            pc_n    = imem_addr;
            cin_n   = flag_reg[CARRY_BIT];
            count_n = cnt_inc;
            if (cnt_inc == len_eff) begin
              busy_n  = 1'b0;
              done_n  = 1'b1;
              state_n = S_DONE;
            end else begin
              addr_n  = imem_addr + 1'b1;
              state_n = S_FETCH;
            end
          end
        end
        S_DONE: begin
          op_n    = NOP_WORD;
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_program_sequencer.sv
// Self-checking bench: ROM-backed runs compared against a cycle-timeline model of
// the sequencer built from the issue rules (two cycles per word, pause stretches time).
module tb_dp_program_sequencer;
  import dp_isa_pkg::*;

  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset, start, pause;
  logic [AW:0]   prog_len;
  logic [AW-1:0] imem_addr, pc;
  logic [15:0]   imem_data, dp_opcode;
  logic          dp_cin, busy, done;
  logic [4:0]    dp_flags;
  logic          we;
  logic [AW-1:0] waddr;
  logic [15:0]   wdata;
  logic [3:0]    noise;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] prog [DEPTH];

  always #5 clk = ~clk;

  // Stand-in datapath: carry is the parity of the word being executed, other flags are noise.
  assign dp_flags = {noise[3], ^dp_opcode, noise[2:0]};

  seq_instr_rom #(.ADDR_W(AW)) u_rom (
    .clk(clk), .we(we), .waddr(waddr), .wdata(wdata), .addr(imem_addr), .data(imem_data)
  );

  dp_program_sequencer #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .prog_len(prog_len),
    .imem_addr(imem_addr), .imem_data(imem_data), .dp_opcode(dp_opcode), .dp_cin(dp_cin),
    .dp_flags(dp_flags), .busy(busy), .done(done), .pc(pc)
  );

  always @(negedge clk) noise <= 4'($urandom);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " opcode"}, 32'(dp_opcode), 32'(OP_NOP));
    chk({tag, " busy"},   32'(busy), 0);
    chk({tag, " done"},   32'(done), 0);
    chk({tag, " pc"},     32'(pc), 0);
    chk({tag, " addr"},   32'(imem_addr), 0);
    chk({tag, " cin"},    32'(dp_cin), 0);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w == OP_HALT) w = 16'h1234;
    return w;
  endfunction

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      we = 1'b1; waddr = AW'(i); wdata = prog[i];
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  // m is model time: 1 = first cycle after the start edge; it advances only on unpaused edges.
  task automatic run(input int len, input int p_start, input int p_len, input bit rnd,
                     input int abort_m, input string tag);
    logic [15:0] w[$];
    int eff, n, done_m, last_m, m, cyc, pleft, k;
    bit halted, adv, pz;
    eff = (len > DEPTH) ? DEPTH : len;
    halted = 1'b0;
    for (int i = 0; i < eff; i++) begin
      if (prog[i] == OP_HALT) begin halted = 1'b1; break; end
      w.push_back(prog[i]);
    end
    n      = w.size();
    done_m = halted ? 2*n + 3 : 2*n + 1;
    last_m = halted ? 2*n + 2 : 2*n + 1;

    @(negedge clk);
    prog_len = (AW+1)'(len); pause = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m = 1; adv = 1'b1; pleft = 0; cyc = 0;
    while (m <= done_m + 1 && cyc < 300) begin
      k = (m - 3) / 2;
      chk({tag, " busy"}, 32'(busy), 32'(m < done_m));
      chk({tag, " done"}, 32'(done), 32'(adv && m == done_m));
      chk({tag, " opcode"}, 32'(dp_opcode),
          32'((m >= 3 && m <= last_m) ? w[k] : OP_NOP));
      if (m < done_m) chk({tag, " addr"}, 32'(imem_addr), 32'((m - 1) / 2));
      if (adv && m >= 3 && m <= last_m && (m % 2) == 1) begin
        chk({tag, " pc"},  32'(pc), 32'(k));
        chk({tag, " cin"}, 32'(dp_cin), (k == 0) ? 32'd0 : 32'(^w[k-1]));
      end
      if (adv && m == done_m && n > 0) chk({tag, " pc at done"}, 32'(pc), 32'(n - 1));
      if (adv && m == abort_m) begin
        #2 reset = 1'b1;
        #1 chk_reset_vals({tag, " abort"});
        @(negedge clk);
        reset = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
          chk({tag, " post-abort busy"}, 32'(busy), 0);
          chk({tag, " post-abort done"}, 32'(done), 0);
          @(negedge clk);
        end
        return;
      end
      pz = 1'b0;
      if (adv && m == p_start) pleft = p_len;
      if (pleft > 0) begin
        pz = 1'b1; pleft--;
      end else if (rnd && m <= done_m && $urandom_range(0, 3) == 0) begin
        pz = 1'b1;
      end
      pause = pz;
      start = (rnd && m < done_m && $urandom_range(0, 4) == 0);
      @(negedge clk);
      cyc++;
      adv = !pz;
      if (adv) m++;
    end
    pause = 1'b0; start = 1'b0;
    chk({tag, " within budget"}, 32'(cyc < 300), 1);
  endtask

  initial begin
    int len;
    reset = 1'b1; start = 1'b0; pause = 1'b0; prog_len = '0;
    we = 1'b0; waddr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < DEPTH; i++) prog[i] = rand_word();
    prog[0] = 16'h5001; prog[1] = 16'h5101; prog[2] = 16'h0150; prog[3] = 16'h02D1;
    load_prog();
    run(4, 0, 0, 1'b0, 0, "four");
    run(4, 5, 3, 1'b0, 0, "four paused");
    run(0, 0, 0, 1'b0, 0, "len0");
    run(31, 0, 0, 1'b0, 0, "len31");
    run(63, 0, 0, 1'b0, 0, "clamp");

    prog[2] = OP_HALT;
    load_prog();
    run(10, 0, 0, 1'b0, 0, "halt@2");

    prog[0] = 16'h0150; prog[1] = 16'h0150; prog[2] = 16'h5001;
    load_prog();
    run(3, 0, 0, 1'b0, 0, "carry");

    for (int i = 0; i < DEPTH; i++) prog[i] = rand_word();
    load_prog();
    run(8, 0, 0, 1'b0, 10, "abort");
    run(8, 0, 0, 1'b0, 0, "rerun");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++)
        prog[i] = ($urandom_range(0, 11) == 0) ? OP_HALT : rand_word();
      load_prog();
      len = $urandom_range(1, 40);
      run(len, 0, 0, 1'b1, 0, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
